pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, successor to the fixed-field inter-stage latches of the five-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control bundle and a data bundle between stages with a valid/ready handshake, stall back-pressure, synchronous flush with bubble insertion, and an optional two-entry skid buffer so `in_ready` is a registered signal. One instance per stage boundary; field packing is done by the instantiating stage.

---
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, stall back-pressure, synchronous flush
// with bubble insertion, and an optional two-entry skid buffer giving a registered in_ready.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_EMPTY | no entry held; out_valid=0
// ST_ONE   | head entry valid, skid empty
// ST_FULL  | head and skid entries valid; in_ready=0 (SKID=1 only)
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 96,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    // Bit 0 is the head valid flag and bit 1 the skid valid flag, so both
    // valids (and the registered in_ready) come straight off the state flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CTRL_W-1:0]   r_head_ctrl;
    logic [DATA_W-1:0]   r_head_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;

    logic                w_head_valid;
    logic                w_skid_valid;
    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_head_ld_in;
    logic                w_head_ld_skid;
    logic                w_skid_ld_in;
    logic                w_clr_ctrl;

    assign w_head_valid = r_state[0];
    assign w_skid_valid = r_state[1];

    assign w_in_ready = (SKID != 0) ? ~w_skid_valid : (~w_head_valid | out_ready);
    assign w_in_fire  = in_valid & w_in_ready & ~flush;
    assign w_out_fire = w_head_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_head_ld_in   = 1'b0;
        w_head_ld_skid = 1'b0;
        w_skid_ld_in   = 1'b0;
        w_clr_ctrl     = 1'b0;
        if (flush) begin
            // The beat on the output this cycle is still consumed if out_ready=1;
            // nothing new is loaded and every held entry becomes a bubble.
            w_state_nxt = ST_EMPTY;
            w_clr_ctrl  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt  = ST_ONE;
                        w_head_ld_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_head_ld_in = 1'b1;
                    end else if (w_in_fire) begin
                        if (SKID != 0) begin
                            w_state_nxt  = ST_FULL;
                            w_skid_ld_in = 1'b1;
                        end else begin
                            w_head_ld_in = 1'b1;
                        end
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt    = ST_ONE;
                        w_head_ld_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_ctrl <= '0;
            r_head_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (w_clr_ctrl) begin
            r_head_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_head_ld_in) begin
                r_head_ctrl <= in_ctrl;
                r_head_data <= in_data;
            end else if (w_head_ld_skid) begin
                r_head_ctrl <= r_skid_ctrl;
                r_head_data <= r_skid_data;
            end
            if (w_skid_ld_in) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_head_valid;
    assign out_ctrl  = w_head_valid ? r_head_ctrl : '0;
    assign out_data  = r_head_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, directed vector table,
// mid-stream reset, then random traffic against a FIFO-capacity reference model.
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 96;

    logic          clk;
    logic          rst_n;
    logic          iv   [2];
    logic          ordy [2];
    logic          fl   [2];
    logic [CW-1:0] ic   [2];
    logic [DW-1:0] idat [2];

    logic          o0_valid, o1_valid, o0_ready, o1_ready;
    logic [CW-1:0] o0_ctrl, o1_ctrl;
    logic [DW-1:0] o0_data, o1_data;

    logic          ov   [2];
    logic          ir   [2];
    logic [CW-1:0] oc   [2];
    logic [DW-1:0] od   [2];

    assign ov[0] = o0_valid;
    assign ov[1] = o1_valid;
    assign ir[0] = o0_ready;
    assign ir[1] = o1_ready;
    assign oc[0] = o0_ctrl;
    assign oc[1] = o1_ctrl;
    assign od[0] = o0_data;
    assign od[1] = o1_data;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_noskid (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(o0_ready), .in_ctrl(ic[0]), .in_data(idat[0]),
        .out_valid(o0_valid), .out_ready(ordy[0]), .out_ctrl(o0_ctrl), .out_data(o0_data)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(o1_ready), .in_ctrl(ic[1]), .in_data(idat[1]),
        .out_valid(o1_valid), .out_ready(ordy[1]), .out_ctrl(o1_ctrl), .out_data(o1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          mode;
        logic        iv;
        logic [15:0] ic;
        logic        ordy;
        logic        fl;
        logic        eov;
        logic [15:0] eoc;
        logic        eir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(int m, logic v, logic [15:0] c, logic r, logic f,
                                 logic eov, logic [15:0] eoc, logic eir);
        vec_t t;
        t.mode = m; t.iv = v; t.ic = c; t.ordy = r; t.fl = f;
        t.eov = eov; t.eoc = eoc; t.eir = eir;
        return t;
    endfunction

    // Reference model: each instance is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         mbuf  [2][2];
    int            mcnt  [2];
    logic [DW-1:0] mlast [2];

    task automatic idle_all();
        for (int m = 0; m < 2; m++) begin
            iv[m] = 1'b0; ordy[m] = 1'b1; fl[m] = 1'b0;
            ic[m] = '0;   idat[m] = '0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s m%0d out_valid", tag, m), DW'(ov[m]), '0);
            check($sformatf("%s m%0d out_ctrl", tag, m), DW'(oc[m]), '0);
            check($sformatf("%s m%0d out_data", tag, m), od[m], '0);
            check($sformatf("%s m%0d in_ready", tag, m), DW'(ir[m]), DW'(1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        #1;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Streaming, stall/skid, and flush on SKID=1; replacement and flush on SKID=0.
        for (int k = 0; k < 8; k++)
            tbl.push_back(row(1, 1'b1, 16'(k + 1), 1'b1, 1'b0, k > 0, 16'(k), 1'b1));
        tbl.push_back(row(1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0008, 1'b1));
        tbl.push_back(row(1, 1'b1, 16'h000A, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(row(1, 1'b1, 16'h000B, 1'b1, 1'b0, 1'b1, 16'h000A, 1'b1));
        tbl.push_back(row(1, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b1, 16'h000B, 1'b1));
        tbl.push_back(row(1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h000B, 1'b0));
        tbl.push_back(row(1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h000B, 1'b0));
        tbl.push_back(row(1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h000C, 1'b1));
        tbl.push_back(row(1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(row(1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(row(1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1));
        tbl.push_back(row(1, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0));
        tbl.push_back(row(1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(row(1, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(row(1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h0055, 1'b1));
        tbl.push_back(row(1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(row(1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(row(0, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(row(0, 1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0));
        tbl.push_back(row(0, 1'b1, 16'h0022, 1'b1, 1'b0, 1'b1, 16'h0011, 1'b1));
        tbl.push_back(row(0, 1'b1, 16'h0033, 1'b1, 1'b0, 1'b1, 16'h0022, 1'b1));
        tbl.push_back(row(0, 1'b1, 16'h0044, 1'b1, 1'b0, 1'b1, 16'h0033, 1'b1));
        tbl.push_back(row(0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0044, 1'b1));
        tbl.push_back(row(0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(row(0, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(row(0, 1'b1, 16'h0066, 1'b0, 1'b1, 1'b1, 16'h0055, 1'b0));
        tbl.push_back(row(0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            int m;
            m = tbl[i].mode;
            @(negedge clk);
            idle_all();
            iv[m] = tbl[i].iv; ic[m] = tbl[i].ic; idat[m] = {6{tbl[i].ic}};
            ordy[m] = tbl[i].ordy; fl[m] = tbl[i].fl;
            #1;
            check($sformatf("tbl[%0d] out_valid", i), DW'(ov[m]), DW'(tbl[i].eov));
            check($sformatf("tbl[%0d] out_ctrl", i), DW'(oc[m]), DW'(tbl[i].eoc));
            check($sformatf("tbl[%0d] in_ready", i), DW'(ir[m]), DW'(tbl[i].eir));
            if (tbl[i].eov)
                check($sformatf("tbl[%0d] out_data", i), od[m], {6{tbl[i].eoc}});
        end

        // Fill the skid instance, then reset asynchronously between edges.
        @(negedge clk);
        idle_all();
        iv[1] = 1'b1; ic[1] = 16'h0AAA; idat[1] = 96'h1; ordy[1] = 1'b0;
        iv[0] = 1'b1; ic[0] = 16'h0BBB; idat[0] = 96'h2; ordy[0] = 1'b0;
        repeat (2) @(negedge clk);
        iv[0] = 1'b0; iv[1] = 1'b0;
        #1;
        check("prereset skid out_valid", DW'(ov[1]), DW'(1));
        check("prereset skid in_ready", DW'(ir[1]), DW'(0));
        check("prereset noskid out_valid", DW'(ov[0]), DW'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_all();
        #1;
        check_reset_state("postreset");

        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0;
            mlast[m] = '0;
        end

        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                iv[m]   = ($urandom_range(0, 3) != 0);
                ic[m]   = CW'($urandom);
                idat[m] = {$urandom, $urandom, $urandom};
                ordy[m] = ((cyc / 64) % 3 == 2) ? ($urandom_range(0, 3) == 0)
                                                : ($urandom_range(0, 3) != 0);
                fl[m]   = ($urandom_range(0, 31) == 0);
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                logic          ev, eir, ofire, ifire;
                logic [CW-1:0] ec;
                logic [DW-1:0] ed;
                beat_t         b;
                ev  = (mcnt[m] > 0);
                ec  = ev ? mbuf[m][0].c : '0;
                ed  = ev ? mbuf[m][0].d : mlast[m];
                eir = (m == 1) ? (mcnt[m] < 2) : (mcnt[m] == 0 || ordy[m]);
                check($sformatf("rnd m%0d c%0d out_valid", m, cyc), DW'(ov[m]), DW'(ev));
                check($sformatf("rnd m%0d c%0d out_ctrl", m, cyc), DW'(oc[m]), DW'(ec));
                check($sformatf("rnd m%0d c%0d out_data", m, cyc), od[m], ed);
                check($sformatf("rnd m%0d c%0d in_ready", m, cyc), DW'(ir[m]), DW'(eir));
                ofire = ev && ordy[m];
                ifire = iv[m] && eir && !fl[m];
                if (ev) mlast[m] = mbuf[m][0].d;
                if (ofire) begin
                    mbuf[m][0] = mbuf[m][1];
                    mcnt[m]--;
                end
                if (fl[m]) begin
                    mcnt[m] = 0;
                end else if (ifire) begin
                    b.c = ic[m];
                    b.d = idat[m];
                    mbuf[m][mcnt[m]] = b;
                    mcnt[m]++;
                end
                if (mcnt[m] > 0) mlast[m] = mbuf[m][0].d;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
